cache_fill_ctrl: RTL

Cache-side miss handler that requests the shared memory port from the memory arbitrator and fills one 16-byte cache block (eight 16-bit words) from the four-cycle pipelined main memory. One instance sits beside each cache (icache and dcache). It is the initiator end of the arbitrator's request/service handshake. It tracks its own in-flight reads so that the shared `data_valid` belonging to the other cache is never consumed.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_fill_ctrl_inflight_pipe.sv | 50 +++++
 rtl/cache_fill_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache fill controllers and the memory model.
// It holds the fill FSM state encoding, the block geometry and the default memory latency.
package cache_pkg;

  // Fill controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Block geometry: eight 16-bit words, so each word is two bytes wide
  localparam int CACHE_WORDS      = 8;
  localparam int CACHE_WORD_BYTES = 2;

  // Cycles from read issue to data_valid in the pipelined main memory
  localparam int CACHE_MEM_LATENCY = 4;

  // Number of byte-offset bits inside a block of the given word count
  function automatic int block_offset_bits(input int words);
    return $clog2(words * CACHE_WORD_BYTES);
  endfunction

  localparam int CACHE_OFF_BITS = block_offset_bits(CACHE_WORDS);

endpackage

// File: rtl/cache_fill_ctrl_inflight_pipe.sv
// inflight_pipe: tracks reads this controller has issued but not yet received.
// Each stage holds a valid bit plus a word index. The pipe shifts every cycle,
// a newly issued read enters at the head, and the tail lines up with data_valid.
module inflight_pipe #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  output logic             tail_valid,
  output logic [IDX_W-1:0] tail_idx
);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [IDX_W-1:0] idx_reg  [DEPTH];
  logic [IDX_W-1:0] idx_next [DEPTH];

  // Each stage takes the previous stage's entry; the head takes the new issue.
  // A clear drops every entry, including one being pushed in that cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign valid_next[gi] = push & ~clr;
      assign idx_next[gi]   = push_idx;
    end else begin : g_body
      assign valid_next[gi] = valid_reg[gi-1] & ~clr;
      assign idx_next[gi]   = idx_reg[gi-1];
    end
  end

  // Shift register update; reset leaves every entry invalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_reg[i] <= '0;
      end
    end else begin
      valid_reg <= valid_next;
      idx_reg   <= idx_next;
    end
  end

  assign tail_valid = valid_reg[DEPTH-1];
  assign tail_idx   = idx_reg[DEPTH-1];

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: per-cache miss handler. On a miss it requests the shared
// memory port, issues one read per word of the block, and writes the returning
// words into the cache. Returns that arrive while this controller has no
// matching in-flight read belong to the other cache and are ignored.
// Optional: define CACHE_FILL_CHECK_EN to add the fill_err output. With it, a
// missing return aborts the fill.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WORDS       = CACHE_WORDS,
  parameter int MEM_LATENCY = CACHE_MEM_LATENCY,
  localparam int IDX_W      = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              request,
  input  logic              service,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              data_valid,
  output logic              fill_we,
  output logic [IDX_W-1:0]  fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              tag_we,
  output logic [ADDR_W-1:0] fill_base,
  output logic              busy,
  output logic              done
`ifdef CACHE_FILL_CHECK_EN
  ,
  output logic              fill_err
`endif
);

  // Counters are one bit wider than the word index so they can reach WORDS
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_BITS = block_offset_bits(WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_BITS) - 1);
  localparam logic [CNT_W-1:0]  WORDS_CNT = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS - 1);

  fill_state_t       state_reg;
  fill_state_t       state_next;
  logic [CNT_W-1:0]  issue_ptr_reg;
  logic [CNT_W-1:0]  recv_cnt_reg;
  logic [ADDR_W-1:0] fill_base_reg;

  logic              miss_take;
  logic              issue;
  logic              accept;
  logic              pipe_clr;
  logic              tail_valid;
  logic [IDX_W-1:0]  tail_idx;

  assign miss_take = (state_reg == IDLE) && miss;
  assign issue     = request && service;
  assign accept    = (state_reg == FILL) && tail_valid && data_valid;

`ifdef CACHE_FILL_CHECK_EN
  logic lost;
  logic fill_err_reg;

  // The tail says a return is due this cycle but memory delivered nothing
  assign lost     = (state_reg == FILL) && tail_valid && !data_valid;
  assign pipe_clr = miss_take || lost;

  // Sticky error flag, cleared only when the next miss is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_err_reg <= 1'b0;
    end else if (miss_take) begin
      fill_err_reg <= 1'b0;
    end else if (lost) begin
      fill_err_reg <= 1'b1;
    end
  end

  assign fill_err = fill_err_reg;
`else
  assign pipe_clr = miss_take;
`endif

  inflight_pipe #(
    .DEPTH (MEM_LATENCY),
    .IDX_W (IDX_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .clr        (pipe_clr),
    .push       (issue),
    .push_idx   (issue_ptr_reg[IDX_W-1:0]),
    .tail_valid (tail_valid),
    .tail_idx   (tail_idx)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: the fill finishes on the cycle the last word is accepted
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (miss) begin
          state_next = FILL;
        end
      end
      FILL: begin
`ifdef CACHE_FILL_CHECK_EN
        if (lost) begin
          state_next = IDLE;
        end else
`endif
        if (accept && (recv_cnt_reg == LAST_CNT)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Block base, issue pointer and receive count; a new miss restarts all three
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_base_reg <= '0;
      issue_ptr_reg <= '0;
      recv_cnt_reg  <= '0;
    end else if (miss_take) begin
      fill_base_reg <= miss_addr & ~OFF_MASK;
      issue_ptr_reg <= '0;
      recv_cnt_reg  <= '0;
    end else begin
      if (issue) begin
        issue_ptr_reg <= issue_ptr_reg + CNT_W'(1);
      end
      if (accept) begin
        recv_cnt_reg <= recv_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Outputs: the request and address are combinational; the fill data path only opens on accept
  always_comb begin
    request   = 1'b0;
    busy      = (state_reg != IDLE);
    done      = 1'b0;
    tag_we    = 1'b0;
    fill_we   = 1'b0;
    fill_word = '0;
    fill_data = '0;
    mem_addr  = fill_base_reg + ADDR_W'({issue_ptr_reg, 1'b0});
    if (state_reg == FILL) begin
      request = (issue_ptr_reg < WORDS_CNT);
    end
    if (state_reg == DONE) begin
      done   = 1'b1;
      tag_we = 1'b1;
    end
    if (accept) begin
      fill_we   = 1'b1;
      fill_word = tail_idx;
      fill_data = mem_data;
    end
  end

  assign fill_base = fill_base_reg;

endmodule
